// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates the single write port between pipeline
// write-back and MDU results, and tracks outstanding MDU destinations for decode interlock.
module rf_wb_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_OUT      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  dec_rd,
  output logic        hazard,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_hold,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_wdata,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [2:0]    OUT_MAX     = 3'(MAX_OUT);

  logic [31:0]   pending;
  logic [2:0]    out_cnt;
  logic [SW-1:0] starve_cnt;
  logic          mdu_acc, iss_acc, blocked;
  logic [31:0]   set_mask, clr_mask, eff;

  // The pipeline always wins unless it is frozen; the hold cycle belongs to the MDU.
  assign mdu_ready = !rst && (!pipe_we || pipe_hold);
  assign mdu_acc   = mdu_valid && mdu_ready;
  assign blocked   = mdu_valid && !mdu_ready;

  assign iss_ready = !rst && !(pending[iss_rd] && (iss_rd != 5'd0)) && (out_cnt < OUT_MAX);
  assign iss_acc   = iss_valid && iss_ready;

  assign set_mask = (iss_acc && (iss_rd != 5'd0)) ? (32'd1 << iss_rd) : 32'd0;
  assign clr_mask = mdu_acc ? (32'd1 << mdu_rd) : 32'd0;

  // A result landing this cycle is forwarded by the register file's write-through.
  assign eff    = pending & ~clr_mask;
  assign hazard = !rst && (((rs1_addr != 5'd0) && eff[rs1_addr]) ||
                           ((rs2_addr != 5'd0) && eff[rs2_addr]) ||
                           ((dec_rd   != 5'd0) && eff[dec_rd]));

  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = 5'd0;
    rf_wdata = 32'd0;
    if (mdu_acc) begin
      rf_we    = 1'b1;
      rf_rd    = mdu_rd;
      rf_wdata = mdu_wdata;
    end else if (!rst && pipe_we && !pipe_hold) begin
      rf_we    = 1'b1;
      rf_rd    = pipe_rd;
      rf_wdata = pipe_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 32'd0;
      out_cnt    <= 3'd0;
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
    end else begin
      pending <= (pending | set_mask) & ~clr_mask;
      case ({iss_acc, mdu_acc})
        2'b10:   out_cnt <= out_cnt + 3'd1;
        2'b01:   out_cnt <= out_cnt - 3'd1;
        default: out_cnt <= out_cnt;
      endcase
      if (blocked) begin
        if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
      // Hold is one cycle wide: during hold mdu_ready is 1, so blocked cannot re-arm it.
      pipe_hold <= blocked && (starve_cnt == STARVE_LAST);
    end
  end

  a_mdu_rd_pending: assert property (@(posedge clk) disable iff (rst)
    (mdu_valid && (mdu_rd != 5'd0)) |-> pending[mdu_rd]);
  a_mdu_outstanding: assert property (@(posedge clk) disable iff (rst)
    mdu_valid |-> (out_cnt != 3'd0));
  a_pipe_rd_free: assert property (@(posedge clk) disable iff (rst)
    (pipe_we && (pipe_rd != 5'd0)) |-> !pending[pipe_rd]);
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed-vector bench for rf_wb_scheduler: cycle-by-cycle input/expected-output tables
// plus a starvation sequence.
module tb_rf_wb_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rd, rs1_addr, rs2_addr, dec_rd;
  logic        hazard;
  logic        pipe_we, pipe_hold;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.STARVE_LIMIT(4), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .dec_rd(dec_rd), .hazard(hazard),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata), .pipe_hold(pipe_hold),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wdata(mdu_wdata), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic        rst, iv;
    logic [4:0]  ird, rs1, rs2, drd;
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pwd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mwd;
  } in_t;

  typedef struct {
    logic        issr, haz, mrdy, we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        hold;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  function automatic in_t ii(input logic r, iv, input logic [4:0] ird, rs1, rs2, drd,
                             input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                             input logic mv, input logic [4:0] mrd, input logic [31:0] mwd);
    in_t x;
    x.rst = r; x.iv = iv; x.ird = ird; x.rs1 = rs1; x.rs2 = rs2; x.drd = drd;
    x.pwe = pwe; x.prd = prd; x.pwd = pwd; x.mv = mv; x.mrd = mrd; x.mwd = mwd;
    return x;
  endfunction

  function automatic exp_t ee(input logic issr, haz, mrdy, we, input logic [4:0] rd,
                              input logic [31:0] wd, input logic hold);
    exp_t x;
    x.issr = issr; x.haz = haz; x.mrdy = mrdy; x.we = we; x.rd = rd; x.wd = wd; x.hold = hold;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, check combinational outputs 1ns later, commit on next rise.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.i.rst; iss_valid = v.i.iv; iss_rd = v.i.ird;
    rs1_addr = v.i.rs1; rs2_addr = v.i.rs2; dec_rd = v.i.drd;
    pipe_we = v.i.pwe; pipe_rd = v.i.prd; pipe_wdata = v.i.pwd;
    mdu_valid = v.i.mv; mdu_rd = v.i.mrd; mdu_wdata = v.i.mwd;
    #1;
    chk({tag, ".iss_ready"}, 32'(iss_ready), 32'(v.e.issr));
    chk({tag, ".hazard"},    32'(hazard),    32'(v.e.haz));
    chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(v.e.mrdy));
    chk({tag, ".rf_we"},     32'(rf_we),     32'(v.e.we));
    chk({tag, ".pipe_hold"}, 32'(pipe_hold), 32'(v.e.hold));
    if (v.e.we) begin
      chk({tag, ".rf_rd"},    32'(rf_rd), 32'(v.e.rd));
      chk({tag, ".rf_wdata"}, rf_wdata,   v.e.wd);
    end
  endtask

  vec_t main_tbl[17];
  vec_t tail_tbl[9];
  vec_t sv;

  initial begin
    rst = 1'b1; iss_valid = 1'b0; iss_rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    dec_rd = 5'd0; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_wdata = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_wdata = 32'd0;

    //                  rst iv ird rs1 rs2 drd pwe prd pwd        mv mrd mwd            issr haz mrdy we rd wd        hold
    main_tbl[0]  = '{ii(1, 1, 1,  0,  0,  0,  1,  2, 32'hFFFF,  0, 0,  32'h0),        ee(0, 0, 0, 0, 0, 32'h0,        0)};
    main_tbl[1]  = '{ii(0, 0, 0,  0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 0, 1, 0, 0, 32'h0,        0)};
    main_tbl[2]  = '{ii(0, 1, 5,  0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 0, 1, 0, 0, 32'h0,        0)};
    main_tbl[3]  = '{ii(0, 0, 0,  5,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 1, 1, 0, 0, 32'h0,        0)};
    main_tbl[4]  = '{ii(0, 0, 0,  0,  5,  0,  1,  9, 32'h1234,  0, 0,  32'h0),        ee(1, 1, 0, 1, 9, 32'h1234,     0)};
    main_tbl[5]  = '{ii(0, 0, 0,  5,  0,  0,  0,  0, 32'h0,     1, 5,  32'hDEADBEEF), ee(1, 0, 1, 1, 5, 32'hDEADBEEF, 0)};
    main_tbl[6]  = '{ii(0, 0, 0,  5,  0,  5,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 0, 1, 0, 0, 32'h0,        0)};
    main_tbl[7]  = '{ii(0, 1, 3,  0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 0, 1, 0, 0, 32'h0,        0)};
    main_tbl[8]  = '{ii(0, 1, 4,  0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 0, 1, 0, 0, 32'h0,        0)};
    main_tbl[9]  = '{ii(0, 1, 6,  0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 0, 1, 0, 0, 32'h0,        0)};
    main_tbl[10] = '{ii(0, 1, 7,  0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 0, 1, 0, 0, 32'h0,        0)};
    main_tbl[11] = '{ii(0, 1, 9,  0,  0,  7,  0,  0, 32'h0,     0, 0,  32'h0),        ee(0, 1, 1, 0, 0, 32'h0,        0)};
    main_tbl[12] = '{ii(0, 1, 3,  0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(0, 0, 1, 0, 0, 32'h0,        0)};
    main_tbl[13] = '{ii(0, 0, 0,  0,  0,  0,  0,  0, 32'h0,     1, 4,  32'h44),       ee(0, 0, 1, 1, 4, 32'h44,       0)};
    main_tbl[14] = '{ii(0, 1, 8,  6,  0,  0,  0,  0, 32'h0,     1, 6,  32'h66),       ee(1, 0, 1, 1, 6, 32'h66,       0)};
    main_tbl[15] = '{ii(0, 1, 4,  8,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 1, 1, 0, 0, 32'h0,        0)};
    main_tbl[16] = '{ii(0, 1, 10, 6,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(0, 0, 1, 0, 0, 32'h0,        0)};

    tail_tbl[0]  = '{ii(0, 1, 0,  4,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 1, 1, 0, 0, 32'h0,        0)};
    tail_tbl[1]  = '{ii(0, 1, 11, 0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(0, 0, 1, 0, 0, 32'h0,        0)};
    tail_tbl[2]  = '{ii(0, 0, 0,  4,  0,  0,  0,  0, 32'h0,     1, 0,  32'h5),        ee(0, 1, 1, 1, 0, 32'h5,        0)};
    tail_tbl[3]  = '{ii(1, 0, 0,  4,  0,  0,  1, 13, 32'h13,    1, 7,  32'h77),       ee(0, 0, 0, 0, 0, 32'h0,        0)};
    tail_tbl[4]  = '{ii(0, 1, 4,  4,  7,  8,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 0, 1, 0, 0, 32'h0,        0)};
    tail_tbl[5]  = '{ii(0, 1, 1,  0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 0, 1, 0, 0, 32'h0,        0)};
    tail_tbl[6]  = '{ii(0, 1, 2,  0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 0, 1, 0, 0, 32'h0,        0)};
    tail_tbl[7]  = '{ii(0, 1, 3,  0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(1, 0, 1, 0, 0, 32'h0,        0)};
    tail_tbl[8]  = '{ii(0, 1, 9,  0,  0,  0,  0,  0, 32'h0,     0, 0,  32'h0),        ee(0, 0, 1, 0, 0, 32'h0,        0)};

    for (int k = 0; k < 17; k++) step(main_tbl[k], $sformatf("main%0d", k));

    // Pending {3,4,7,8}, four in flight. Pipe writes every cycle; MDU result for x3 waits.
    for (int c = 1; c <= 6; c++) begin
      sv.i = ii(0, 0, 0, 0, 0, 0, 1, 12, 32'hAAAA0001, (c <= 5), 3, 32'h33333333);
      if (c <= 4)      sv.e = ee(0, 0, 0, 1, 12, 32'hAAAA0001, 0);
      else if (c == 5) sv.e = ee(0, 0, 1, 1, 3,  32'h33333333, 1);
      else             sv.e = ee(1, 0, 0, 1, 12, 32'hAAAA0001, 0);
      step(sv, $sformatf("starve%0d", c));
    end

    for (int k = 0; k < 9; k++) step(tail_tbl[k], $sformatf("tail%0d", k));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
